i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) endpoint: the responder side of the bus that the I2C repeater tracks. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs, and exchanges bytes with local logic through a pulse-based write/read interface. It sits behind the board's open-drain pads; it drives SDA low only and never drives SCL (no clock stretching).

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this target answers.
- `FILTER_LEN`, default 5: consecutive identical samples (3..8) required before a filtered line changes.
- `system_clk`, in, 1: the block's only clock; every output is registered on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `scl_in`, in, 1: bus SCL level from pad.
- `sda_in`, in, 1: bus SDA level from pad.
- `sda_oe`, out, 1: 1 = pull SDA low; 0 = release. Pad: `sda = sda_oe ? 0 : 1'bz`.
- `wr_valid`, out, 1: one-cycle pulse; `wr_data` holds a received byte.
- `wr_data`, out, 8: last received write byte; held until the next byte.
- `wr_first`, out, 1: qualifies `wr_valid`; 1 = first data byte after the address.
- `rd_req`, out, 1: one-cycle pulse requesting the next read byte.
- `rd_data`, in, 8: must be valid on the cycle after `rd_req`.
- `busy`, out, 1: 1 from address match until STOP, repeated START, or NACK.

## Operation
- Filter: per line, a `FILTER_LEN`-deep shift register; the filtered value changes only when all samples agree. The filtered SCL gives `scl_rise`/`scl_fall` one-cycle strobes.
- START: filtered SCL high on this and the previous cycle, and SDA falls. STOP: same, but SDA rises.
- START (including a repeated START) from any state → ADDR, bit counter = 7, `sda_oe`=0.
- STOP from any state → IDLE, `sda_oe`=0, `busy`=0.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- Bits are sampled on `scl_rise` (MSB first). SDA output changes only on `scl_fall`.
- ADDR:
  - Shift 8 bits: 7 address bits plus R/W.
  - On the `scl_fall` after bit 8 with a match: `sda_oe`=1, `busy`=1, → ADDR_ACK.
  - Mismatch: → IGNORE, which waits for START or STOP.
- ADDR_ACK, on `scl_fall`:
  - W: release SDA, → WR_DATA.
  - R: pulse `rd_req`, → RD_DATA.
- WR_DATA, on the `scl_fall` after bit 8:
  - Update `wr_data`, pulse `wr_valid`. `wr_first`=1 only for the first byte after the address.
  - Set `sda_oe`=1 (writes are always ACKed), → WR_ACK.
- WR_ACK, on `scl_fall`: release SDA, → WR_DATA.
- RD_DATA:
  - The cycle after `rd_req`: load `rd_data` into the shift register and set `sda_oe = ~rd_data[7]`.
  - On each following `scl_fall`: shift out the next bit.
  - On the `scl_fall` after bit 8: release SDA, → RD_ACK.
- RD_ACK: sample the master's bit on `scl_rise`, then act on `scl_fall`:
  - 0 (ACK): pulse `rd_req`, → RD_DATA.
  - 1 (NACK): `busy`=0, → IGNORE.
- Bit counter: 3 bits, wraps 0→7 at each byte boundary.
- Priority: reset > START/STOP > `scl_fall` > `scl_rise`.

## Timing
- Reset values: `sda_oe`=0, `wr_valid`=0, `wr_first`=0, `wr_data`=8'h00, `rd_req`=0, `busy`=0. State = IDLE; filters preset to all-ones.
- Latency from a pad change to the filtered value: `FILTER_LEN` cycles. START/STOP is flagged one cycle later.
- `sda_oe` updates on the cycle after `scl_fall` is asserted, i.e. `FILTER_LEN`+1 cycles after the pad SCL falls. Exception: the first read bit appears one cycle later still, because of the `rd_data` load.
- Minimum ratio: `system_clk` ≥ 16× SCL.
- A glitch shorter than `FILTER_LEN` cycles produces no edge.
- Reset mid-transfer: SDA is released on the following cycle. No `wr_valid` is issued for a partial byte.

## Configuration
- `I2C_TARGET_GENERAL_CALL_EN` defined:
  - Address 7'h00 with W is also ACKed and handled as a normal write.
  - Adds output `gcall` (1 bit, reset 0). It is set at the ACK of a general-call address and cleared on STOP/START.
  - Address 7'h00 with R goes to IGNORE.
- Macro not defined: 7'h00 is treated as a mismatch, and the `gcall` port does not exist.

## Structure
- Package `i2c_pkg`: state encoding constants, `I2C_ADDR_W`=7, `I2C_BYTE_W`=8, bit value `I2C_RW_READ`=1.
- Sub-module `i2c_bus_sampler`: both line filters, edge detection, and the START/STOP strobes. Outputs `scl_rise`, `scl_fall`, `sda_f`, `start`, `stop`.
- Top level: FSM, shift registers, counters.

## Test plan
- Write: START, 0xA0 (0x50+W), 0xA5, 0x3C, STOP → ACK on the address and both bytes. Two `wr_valid` pulses: 0xA5 with `wr_first`=1, then 0x3C with `wr_first`=0. `busy` ends 0.
- Mismatch: START, 0xA2 (0x51+W), 0xFF → `sda_oe` stays 0 throughout; no `wr_valid`, no `rd_req`.
- Read:
  - START, 0xA1, `rd_data`=0x3C then 0x81, master ACK then NACK, STOP.
  - Required: SDA reads 00111100 then 10000001; exactly two `rd_req` pulses; `busy`=0 after the NACK.
- Repeated START after 4 bits of a write byte → no `wr_valid`; state ADDR. A following 0xA1 is ACKed and a read proceeds.
- Robustness:
  - A 3-cycle SCL low glitch with `FILTER_LEN`=5 → no bit shifted.
  - `reset` asserted while `sda_oe`=1 in WR_ACK → `sda_oe`=0 the next cycle and all outputs at reset values.
- With `I2C_TARGET_GENERAL_CALL_EN`: START, 0x00, 0x06 → ACKs; `gcall`=1; `wr_valid` with 0x06. Without the macro: no ACK.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared widths, R/W encoding and FSM state type for i2c_target.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_pkg;

    localparam int   I2C_ADDR_W  = 7;
    localparam int   I2C_BYTE_W  = 8;
    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_t;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_bus_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_sampler
//  Description : SCL/SDA glitch filters, SCL edge strobes and START/STOP strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_bus_sampler #(
    parameter int FILTER_LEN = 5
) (
    input  logic system_clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_f,
    output logic start,
    output logic stop
);

    // The live pad sample is the newest entry of the FILTER_LEN-wide window,
    // so a clean level change reaches the filtered output in FILTER_LEN cycles.
    logic [FILTER_LEN-2:0] r_scl_sh;
    logic [FILTER_LEN-2:0] r_sda_sh;
    logic [FILTER_LEN-1:0] w_scl_win;
    logic [FILTER_LEN-1:0] w_sda_win;
    logic                  r_scl_f;
    logic                  r_scl_fd;
    logic                  r_sda_f;
    logic                  r_sda_fd;

    assign w_scl_win = {r_scl_sh, scl_in};
    assign w_sda_win = {r_sda_sh, sda_in};

    always_ff @(posedge system_clk) begin
        if (reset) begin
            r_scl_sh <= '1;
            r_sda_sh <= '1;
            r_scl_f  <= 1'b1;
            r_scl_fd <= 1'b1;
            r_sda_f  <= 1'b1;
            r_sda_fd <= 1'b1;
        end else begin
            r_scl_sh <= w_scl_win[FILTER_LEN-2:0];
            r_sda_sh <= w_sda_win[FILTER_LEN-2:0];
            if (&w_scl_win)
                r_scl_f <= 1'b1;
            else if (~|w_scl_win)
                r_scl_f <= 1'b0;
            if (&w_sda_win)
                r_sda_f <= 1'b1;
            else if (~|w_sda_win)
                r_sda_f <= 1'b0;
            r_scl_fd <= r_scl_f;
            r_sda_fd <= r_sda_f;
        end
    end

    assign scl_rise = r_scl_f & ~r_scl_fd;
    assign scl_fall = ~r_scl_f & r_scl_fd;
    assign sda_f    = r_sda_f;
    assign start    = r_scl_f & r_scl_fd & r_sda_fd & ~r_sda_f;
    assign stop     = r_scl_f & r_scl_fd & ~r_sda_fd & r_sda_f;

endmodule : i2c_bus_sampler
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target
//  Description : I2C target endpoint: address match, ACK, pulse write/read port.
//                Optional general call answer: I2C_TARGET_GENERAL_CALL_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50,
    parameter int                    FILTER_LEN = 5
) (
    input  logic                  system_clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic                  wr_valid,
    output logic [I2C_BYTE_W-1:0] wr_data,
    output logic                  wr_first,
    output logic                  rd_req,
    input  logic [I2C_BYTE_W-1:0] rd_data,
    output logic                  busy
`ifdef I2C_TARGET_GENERAL_CALL_EN
    ,
    output logic                  gcall
`endif
);

    logic                  w_scl_rise;
    logic                  w_scl_fall;
    logic                  w_sda_f;
    logic                  w_start;
    logic                  w_stop;
    logic                  w_addr_ok;
`ifdef I2C_TARGET_GENERAL_CALL_EN
    logic                  w_gcall_hit;
`endif

    i2c_state_t            r_state;
    logic [I2C_BYTE_W-1:0] r_shift;
    logic [2:0]            r_bit_cnt;
    logic                  r_byte_done;
    logic                  r_first;
    logic                  r_rw;
    logic                  r_rd_load;
    logic                  r_mst_bit;

    i2c_bus_sampler #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sampler (
        .system_clk (system_clk),
        .reset      (reset),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .scl_rise   (w_scl_rise),
        .scl_fall   (w_scl_fall),
        .sda_f      (w_sda_f),
        .start      (w_start),
        .stop       (w_stop)
    );

`ifdef I2C_TARGET_GENERAL_CALL_EN
    assign w_gcall_hit = (r_shift[I2C_BYTE_W-1:1] == '0) && (r_shift[0] != I2C_RW_READ);
    assign w_addr_ok   = (r_shift[I2C_BYTE_W-1:1] == SLAVE_ADDR) || w_gcall_hit;
`else
    assign w_addr_ok   = (r_shift[I2C_BYTE_W-1:1] == SLAVE_ADDR);
`endif

    always_ff @(posedge system_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= 3'd7;
            r_byte_done <= 1'b0;
            r_first     <= 1'b0;
            r_rw        <= 1'b0;
            r_rd_load   <= 1'b0;
            r_mst_bit   <= 1'b1;
            sda_oe      <= 1'b0;
            wr_valid    <= 1'b0;
            wr_data     <= '0;
            wr_first    <= 1'b0;
            rd_req      <= 1'b0;
            busy        <= 1'b0;
`ifdef I2C_TARGET_GENERAL_CALL_EN
            gcall       <= 1'b0;
`endif
        end else begin
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            if (w_start || w_stop) begin
                r_state     <= w_start ? ST_ADDR : ST_IDLE;
                r_bit_cnt   <= 3'd7;
                r_byte_done <= 1'b0;
                r_rd_load   <= 1'b0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
`ifdef I2C_TARGET_GENERAL_CALL_EN
                gcall       <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_ADDR, ST_WR_DATA: begin
                        if (w_scl_fall) begin
                            if (r_byte_done) begin
                                r_byte_done <= 1'b0;
                                if (r_state == ST_WR_DATA) begin
                                    wr_data  <= r_shift;
                                    wr_valid <= 1'b1;
                                    wr_first <= r_first;
                                    r_first  <= 1'b0;
                                    sda_oe   <= 1'b1;
                                    r_state  <= ST_WR_ACK;
                                end else if (w_addr_ok) begin
                                    sda_oe  <= 1'b1;
                                    busy    <= 1'b1;
                                    r_rw    <= r_shift[0];
                                    r_state <= ST_ADDR_ACK;
`ifdef I2C_TARGET_GENERAL_CALL_EN
                                    gcall   <= w_gcall_hit;
`endif
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end else if (w_scl_rise) begin
                            r_shift   <= {r_shift[I2C_BYTE_W-2:0], w_sda_f};
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            if (r_bit_cnt == 3'd0)
                                r_byte_done <= 1'b1;
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (r_rw == I2C_RW_READ) begin
                                rd_req    <= 1'b1;
                                r_rd_load <= 1'b1;
                                r_state   <= ST_RD_DATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_first <= 1'b1;
                                r_state <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            sda_oe  <= 1'b0;
                            r_state <= ST_WR_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        // Local logic answers rd_req one cycle later; load then.
                        if (r_rd_load) begin
                            r_rd_load <= 1'b0;
                            r_shift   <= rd_data;
                            sda_oe    <= ~rd_data[I2C_BYTE_W-1];
                        end else if (w_scl_fall) begin
                            if (r_byte_done) begin
                                r_byte_done <= 1'b0;
                                sda_oe      <= 1'b0;
                                r_state     <= ST_RD_ACK;
                            end else begin
                                r_shift <= {r_shift[I2C_BYTE_W-2:0], 1'b0};
                                sda_oe  <= ~r_shift[I2C_BYTE_W-2];
                            end
                        end else if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            if (r_bit_cnt == 3'd0)
                                r_byte_done <= 1'b1;
                        end
                    end
                    ST_RD_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_mst_bit) begin
                                rd_req    <= 1'b1;
                                r_rd_load <= 1'b1;
                                r_state   <= ST_RD_DATA;
                            end else begin
                                busy    <= 1'b0;
                                r_state <= ST_IGNORE;
                            end
                        end else if (w_scl_rise) begin
                            r_mst_bit <= w_sda_f;
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule : i2c_target
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target
//  Description : Directed bus-master bench for i2c_target (open-drain SDA model).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int H = 20;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       scl   = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_valid, wr_first, rd_req, busy;
    logic [7:0] wr_data;
    logic [7:0] rd_data = 8'h00;
`ifdef I2C_TARGET_GENERAL_CALL_EN
    logic       gcall;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int oe_cnt   = 0;
    logic [7:0] wr_log_d [8];
    logic       wr_log_f [8];
    logic [7:0] rd_vals  [8];
    logic       glitch_en = 1'b0;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target #(
        .SLAVE_ADDR (7'h50),
        .FILTER_LEN (5)
    ) dut (
        .system_clk (clk),
        .reset      (rst),
        .scl_in     (scl),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_first   (wr_first),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .busy       (busy)
`ifdef I2C_TARGET_GENERAL_CALL_EN
        ,
        .gcall      (gcall)
`endif
    );

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_log_d[wr_cnt & 7] = wr_data;
            wr_log_f[wr_cnt & 7] = wr_first;
            wr_cnt++;
        end
        if (rd_req) begin
            rd_data = rd_vals[rd_cnt & 7];
            rd_cnt++;
        end
        if (sda_oe)
            oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        wait_cyc(4);
        sda_m = b;
        wait_cyc(H - 4);
        scl = 1'b1;
        wait_cyc(H / 2);
        s = sda_line;
        if (glitch_en) begin
            glitch_en = 1'b0;
            wait_cyc(2);
            scl = 1'b0;
            wait_cyc(3);
            scl = 1'b1;
            wait_cyc(H / 2 - 5);
        end else begin
            wait_cyc(H / 2);
        end
        scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_cyc(4);
        sda_m = 1'b1;
        wait_cyc(H);
        scl = 1'b1;
        wait_cyc(H);
        sda_m = 1'b0;
        wait_cyc(H);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_cyc(4);
        sda_m = 1'b0;
        wait_cyc(H);
        scl = 1'b1;
        wait_cyc(H);
        sda_m = 1'b1;
        wait_cyc(H);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--)
            clk_bit(d[i], s);
        clk_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         wr0, rd0, oe0;

        rd_vals[0] = 8'h3C;
        rd_vals[1] = 8'h81;
        rd_vals[2] = 8'h5A;
        for (int i = 3; i < 8; i++)
            rd_vals[i] = 8'hEE;

        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(5);
        check("rst_sda_oe",   {31'd0, sda_oe},   32'd0);
        check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_wr_first", {31'd0, wr_first}, 32'd0);
        check("rst_wr_data",  {24'd0, wr_data},  32'h00);
        check("rst_rd_req",   {31'd0, rd_req},   32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);

        // Write 0x50+W, 0xA5, 0x3C
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'hA5, ack);
        check("wr_b0_ack", {31'd0, ack}, 32'd1);
        check("wr_busy", {31'd0, busy}, 32'd1);
        write_byte(8'h3C, ack);
        check("wr_b1_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("wr_count", wr_cnt - wr0, 32'd2);
        check("wr_d0", {24'd0, wr_log_d[wr0 & 7]}, 32'hA5);
        check("wr_f0", {31'd0, wr_log_f[wr0 & 7]}, 32'd1);
        check("wr_d1", {24'd0, wr_log_d[(wr0 + 1) & 7]}, 32'h3C);
        check("wr_f1", {31'd0, wr_log_f[(wr0 + 1) & 7]}, 32'd0);
        check("wr_busy_end", {31'd0, busy}, 32'd0);

        // Address mismatch 0x51+W
        wr0 = wr_cnt; rd0 = rd_cnt; oe0 = oe_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        check("mm_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'hFF, ack);
        i2c_stop();
        check("mm_oe", oe_cnt - oe0, 32'd0);
        check("mm_wr", wr_cnt - wr0, 32'd0);
        check("mm_rd", rd_cnt - rd0, 32'd0);

        // Read two bytes, master ACK then NACK
        rd0 = rd_cnt;
        i2c_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(d, 1'b0);
        check("rd_b0", {24'd0, d}, 32'h3C);
        read_byte(d, 1'b1);
        check("rd_b1", {24'd0, d}, 32'h81);
        wait_cyc(10);
        check("rd_busy_nack", {31'd0, busy}, 32'd0);
        check("rd_req_count", rd_cnt - rd0, 32'd2);
        i2c_stop();

        // Repeated START after 4 bits of a write byte
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        clk_bit(1'b1, s);
        clk_bit(1'b0, s);
        clk_bit(1'b1, s);
        clk_bit(1'b1, s);
        check("rs_busy_before", {31'd0, busy}, 32'd1);
        i2c_start();
        wait_cyc(2);
        check("rs_busy_after", {31'd0, busy}, 32'd0);
        write_byte(8'hA1, ack);
        check("rs_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(d, 1'b1);
        check("rs_rd", {24'd0, d}, 32'h5A);
        check("rs_no_wr", wr_cnt - wr0, 32'd0);
        i2c_stop();

        // 3-cycle SCL low glitch inside the first data bit
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        glitch_en = 1'b1;
        write_byte(8'h55, ack);
        check("gl_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("gl_count", wr_cnt - wr0, 32'd1);
        check("gl_data", {24'd0, wr_data}, 32'h55);

        // Reset while ACKing a write byte
        i2c_start();
        write_byte(8'hA0, ack);
        for (int i = 7; i >= 0; i--)
            clk_bit(((8'h77 >> i) & 8'h01) != 8'h00, s);
        wait_cyc(10);
        check("rs_wrack_oe", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        wait_cyc(1);
        check("mid_rst_oe",    {31'd0, sda_oe},   32'd0);
        check("mid_rst_busy",  {31'd0, busy},     32'd0);
        check("mid_rst_wdata", {24'd0, wr_data},  32'h00);
        check("mid_rst_first", {31'd0, wr_first}, 32'd0);
        check("mid_rst_valid", {31'd0, wr_valid}, 32'd0);
        check("mid_rst_rdreq", {31'd0, rd_req},   32'd0);
        rst   = 1'b0;
        scl   = 1'b1;
        sda_m = 1'b1;
        wait_cyc(3 * H);

        // General call address
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'h00, ack);
`ifdef I2C_TARGET_GENERAL_CALL_EN
        check("gc_addr_ack", {31'd0, ack}, 32'd1);
        check("gc_flag", {31'd0, gcall}, 32'd1);
        write_byte(8'h06, ack);
        check("gc_b0_ack", {31'd0, ack}, 32'd1);
        check("gc_data", {24'd0, wr_data}, 32'h06);
        check("gc_count", wr_cnt - wr0, 32'd1);
        i2c_stop();
        check("gc_flag_clr", {31'd0, gcall}, 32'd0);
`else
        check("gc_addr_nack", {31'd0, ack}, 32'd0);
        write_byte(8'h06, ack);
        i2c_stop();
        check("gc_no_wr", wr_cnt - wr0, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_i2c_target
`default_nettype wire
